// File: rtl/pkt_fifo_pkg.sv
// Shared definitions for the packet FIFO controller: write-side FSM
// encoding and the default storage address width.
package pkt_fifo_pkg;

  // Default storage address width; depth is 2**PWIDHT_DEF words.
  localparam int PWIDHT_DEF = 2;

  // Write-side packet state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no open packet
    ST_RECV = 2'd1,  // packet open, words written speculatively
    ST_DROP = 2'd2   // overflowed packet, swallowing its remaining words
  } wr_state_e;

endpackage

// File: rtl/pkt_fifo_ptr.sv
// FIFO pointer: pWIDHT+1 bits (address plus wrap bit), modulo
// 2**(pWIDHT+1). Load has priority over increment.
module pkt_fifo_ptr
  import pkt_fifo_pkg::*;
#(
  parameter int pWIDHT = PWIDHT_DEF
) (
  input  logic            iclk,
  input  logic            irst,
  input  logic            iinc,
  input  logic            iload,
  input  logic [pWIDHT:0] iload_val,
  output logic [pWIDHT:0] optr
);

  localparam logic [pWIDHT:0] ONE = {{pWIDHT{1'b0}}, 1'b1};

  // Pointer register: reset, reload or step by one.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge iclk) begin
    if (irst) begin
      optr <= '0;
    end else if (iload) begin
      optr <= iload_val;
    end else if (iinc) begin
      optr <= optr + ONE;
    end
  end

endmodule

// File: rtl/pkt_fifo_ctrl.sv
// Packet FIFO controller. Words are written speculatively behind
// commit_ptr and only become visible to the reader once the packet's last
// word is accepted. A packet that overflows is rolled back and the rest of
// it is discarded.
// NOTE: the storage array lives outside this block and is never cleared;
// resetting the pointers alone makes any stale contents unreachable.
module pkt_fifo_ctrl
  import pkt_fifo_pkg::*;
#(
  parameter int pWIDHT = PWIDHT_DEF
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              iwr,
  input  logic              ilast,
  input  logic              ird,
  output logic              owr_en,
  output logic [pWIDHT-1:0] ow_addr,
  output logic [pWIDHT-1:0] or_addr,
  output logic              oempty,
  output logic              ofull,
  output logic [pWIDHT:0]   ocount,
  output logic              oovf
);

  localparam logic [pWIDHT:0] ONE       = {{pWIDHT{1'b0}}, 1'b1};
  localparam logic [pWIDHT:0] FULL_DIST = {1'b1, {pWIDHT{1'b0}}};

  logic [pWIDHT:0] wr_ptr, commit_ptr, rd_ptr;
  logic [pWIDHT:0] fill, commit_val;
  logic            wr_inc, wr_load, commit_load, ovf_evt, rd_acc, ovf_q;
  wr_state_e       state_q, state_d;

  // Status is derived from registered pointers only.
  assign fill       = wr_ptr - rd_ptr;
  assign ofull      = (fill == FULL_DIST);
  assign oempty     = (commit_ptr == rd_ptr);
  assign ocount     = commit_ptr - rd_ptr;
  assign ow_addr    = wr_ptr[pWIDHT-1:0];
  assign or_addr    = rd_ptr[pWIDHT-1:0];
  assign commit_val = wr_ptr + ONE;
  assign rd_acc     = ird && !oempty;
  assign oovf       = ovf_q;

  // Write FSM next state and write-side controls.
  // NOTE: every output gets a default before the case, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    owr_en      = 1'b0;
    wr_inc      = 1'b0;
    wr_load     = 1'b0;
    commit_load = 1'b0;
    ovf_evt     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_RECV: begin
        if (iwr && !irst) begin
          if (ofull) begin
            // Roll back the open packet and swallow whatever is left of it.
            wr_load = 1'b1;
            ovf_evt = 1'b1;
            state_d = ilast ? ST_IDLE : ST_DROP;
          end else begin
            owr_en = 1'b1;
            wr_inc = 1'b1;
            if (ilast) begin
              commit_load = 1'b1;
              state_d     = ST_IDLE;
            end else begin
              state_d = ST_RECV;
            end
          end
        end
      end
      ST_DROP: begin
        if (iwr && ilast) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and registered overflow pulse.
  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q <= ST_IDLE;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_evt;
    end
  end

  // Speculative write pointer; reloads from commit_ptr on overflow.
  pkt_fifo_ptr #(.pWIDHT(pWIDHT)) u_wr_ptr (
    .iclk      (iclk),
    .irst      (irst),
    .iinc      (wr_inc),
    .iload     (wr_load),
    .iload_val (commit_ptr),
    .optr      (wr_ptr)
  );

  // Commit pointer; jumps past the last word in the same edge wr_ptr steps.
  pkt_fifo_ptr #(.pWIDHT(pWIDHT)) u_commit_ptr (
    .iclk      (iclk),
    .irst      (irst),
    .iinc      (1'b0),
    .iload     (commit_load),
    .iload_val (commit_val),
    .optr      (commit_ptr)
  );

  // Read pointer; only moves over committed words.
  pkt_fifo_ptr #(.pWIDHT(pWIDHT)) u_rd_ptr (
    .iclk      (iclk),
    .irst      (irst),
    .iinc      (rd_acc),
    .iload     (1'b0),
    .iload_val ('0),
    .optr      (rd_ptr)
  );

endmodule

// File: tb/tb_pkt_fifo_ctrl.sv
// Directed bench for pkt_fifo_ctrl at depth 4: commit visibility, reads,
// wrap, overflow rollback, drop state, simultaneous read/write and reset.
module tb_pkt_fifo_ctrl;

  localparam int W = 2;

  typedef struct {
    logic         wen;
    logic [W-1:0] waddr;
    logic [W-1:0] raddr;
  } exp_port_t;

  logic         iclk = 1'b0;
  logic         irst = 1'b0;
  logic         iwr = 1'b0;
  logic         ilast = 1'b0;
  logic         ird = 1'b0;
  logic         owr_en;
  logic [W-1:0] ow_addr;
  logic [W-1:0] or_addr;
  logic         oempty;
  logic         ofull;
  logic [W:0]   ocount;
  logic         oovf;

  int n_tests = 0;
  int n_fail  = 0;

  exp_port_t sb_q[$];

  pkt_fifo_ctrl #(.pWIDHT(W)) dut (
    .iclk    (iclk),
    .irst    (irst),
    .iwr     (iwr),
    .ilast   (ilast),
    .ird     (ird),
    .owr_en  (owr_en),
    .ow_addr (ow_addr),
    .or_addr (or_addr),
    .oempty  (oempty),
    .ofull   (ofull),
    .ocount  (ocount),
    .oovf    (oovf)
  );

  always #5 iclk = ~iclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, push the expected storage-port values,
  // pop and compare them before the edge, then advance past the edge.
  task automatic step(input string tag, input logic wr, input logic last, input logic rd,
                      input logic e_wen, input logic [W-1:0] e_waddr, input logic [W-1:0] e_raddr);
    exp_port_t e;
    @(negedge iclk);
    iwr   = wr;
    ilast = last;
    ird   = rd;
    sb_q.push_back('{wen: e_wen, waddr: e_waddr, raddr: e_raddr});
    #1;
    e = sb_q.pop_front();
    check({tag, ".owr_en"},  {31'd0, owr_en},  {31'd0, e.wen});
    check({tag, ".ow_addr"}, {30'd0, ow_addr}, {30'd0, e.waddr});
    check({tag, ".or_addr"}, {30'd0, or_addr}, {30'd0, e.raddr});
    @(posedge iclk);
    #1;
    iwr   = 1'b0;
    ilast = 1'b0;
    ird   = 1'b0;
  endtask

  task automatic status(input string tag, input logic e_empty, input logic e_full,
                        input logic [W:0] e_count, input logic e_ovf);
    check({tag, ".oempty"}, {31'd0, oempty}, {31'd0, e_empty});
    check({tag, ".ofull"},  {31'd0, ofull},  {31'd0, e_full});
    check({tag, ".ocount"}, {29'd0, ocount}, {29'd0, e_count});
    check({tag, ".oovf"},   {31'd0, oovf},   {31'd0, e_ovf});
  endtask

  task automatic do_reset();
    @(negedge iclk);
    irst  = 1'b1;
    iwr   = 1'b0;
    ilast = 1'b0;
    ird   = 1'b0;
    @(posedge iclk);
    #1;
    irst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    status("rst", 1'b1, 1'b0, 3'd0, 1'b0);
    step("rst_idle", 0, 0, 0, 1'b0, 2'd0, 2'd0);

    // 3-word packet: invisible until the cycle after its last word
    step("p3_w0", 1, 0, 0, 1'b1, 2'd0, 2'd0);  status("p3_s0", 1'b1, 1'b0, 3'd0, 1'b0);
    step("p3_w1", 1, 0, 0, 1'b1, 2'd1, 2'd0);  status("p3_s1", 1'b1, 1'b0, 3'd0, 1'b0);
    step("p3_w2", 1, 1, 0, 1'b1, 2'd2, 2'd0);  status("p3_s2", 1'b0, 1'b0, 3'd3, 1'b0);

    // Drain it, then a read on empty must be ignored
    step("rd0", 0, 0, 1, 1'b0, 2'd3, 2'd0);    status("rd0_s", 1'b0, 1'b0, 3'd2, 1'b0);
    step("rd1", 0, 0, 1, 1'b0, 2'd3, 2'd1);    status("rd1_s", 1'b0, 1'b0, 3'd1, 1'b0);
    step("rd2", 0, 0, 1, 1'b0, 2'd3, 2'd2);    status("rd2_s", 1'b1, 1'b0, 3'd0, 1'b0);
    step("rd_empty", 0, 0, 1, 1'b0, 2'd3, 2'd3);  status("rd_empty_s", 1'b1, 1'b0, 3'd0, 1'b0);
    step("rd_hold", 0, 0, 0, 1'b0, 2'd3, 2'd3);

    // Wrap: 2-word packet lands at addresses 3 then 0
    step("wrap_w0", 1, 0, 0, 1'b1, 2'd3, 2'd3);
    step("wrap_w1", 1, 1, 0, 1'b1, 2'd0, 2'd3);  status("wrap_s", 1'b0, 1'b0, 3'd2, 1'b0);
    step("wrap_r0", 0, 0, 1, 1'b0, 2'd1, 2'd3);
    step("wrap_r1", 0, 0, 1, 1'b0, 2'd1, 2'd0);  status("wrap_r_s", 1'b1, 1'b0, 3'd0, 1'b0);

    // Reset mid-packet after two words: everything back to zero, no overflow
    step("mid_w0", 1, 0, 0, 1'b1, 2'd1, 2'd1);
    step("mid_w1", 1, 0, 0, 1'b1, 2'd2, 2'd1);
    do_reset();
    status("mid_rst", 1'b1, 1'b0, 3'd0, 1'b0);
    step("mid_after", 0, 0, 0, 1'b0, 2'd0, 2'd0);

    // 5-word packet into empty: 4 written, 5th rejected, rolled back
    step("ov_w0", 1, 0, 0, 1'b1, 2'd0, 2'd0);
    step("ov_w1", 1, 0, 0, 1'b1, 2'd1, 2'd0);
    step("ov_w2", 1, 0, 0, 1'b1, 2'd2, 2'd0);
    step("ov_w3", 1, 0, 0, 1'b1, 2'd3, 2'd0);  status("ov_full", 1'b1, 1'b1, 3'd0, 1'b0);
    step("ov_w4", 1, 1, 0, 1'b0, 2'd0, 2'd0);  status("ov_pulse", 1'b1, 1'b0, 3'd0, 1'b1);
    step("ov_idle", 0, 0, 0, 1'b0, 2'd0, 2'd0);  status("ov_clear", 1'b1, 1'b0, 3'd0, 1'b0);

    // Fill completely with one committed packet from address 0
    step("fl_w0", 1, 0, 0, 1'b1, 2'd0, 2'd0);
    step("fl_w1", 1, 0, 0, 1'b1, 2'd1, 2'd0);
    step("fl_w2", 1, 0, 0, 1'b1, 2'd2, 2'd0);
    step("fl_w3", 1, 1, 0, 1'b1, 2'd3, 2'd0);  status("fl_s", 1'b0, 1'b1, 3'd4, 1'b0);

    // Full with write and read together: write rejected, read taken
    step("fl_rw", 1, 1, 1, 1'b0, 2'd0, 2'd0);  status("fl_rw_s", 1'b0, 1'b0, 3'd3, 1'b1);
    step("fl_idle", 0, 0, 0, 1'b0, 2'd0, 2'd1);  status("fl_idle_s", 1'b0, 1'b0, 3'd3, 1'b0);

    // Commit and read in the same cycle: count = 3 + 1 - 1
    step("cr", 1, 1, 1, 1'b1, 2'd0, 2'd1);     status("cr_s", 1'b0, 1'b0, 3'd3, 1'b0);

    // Overflow without ilast enters DROP; rest of packet is swallowed
    step("dr_w0", 1, 0, 0, 1'b1, 2'd1, 2'd2);  status("dr_full", 1'b0, 1'b1, 3'd3, 1'b0);
    step("dr_ovf", 1, 0, 0, 1'b0, 2'd2, 2'd2); status("dr_ovf_s", 1'b0, 1'b0, 3'd3, 1'b1);
    step("dr_ign0", 1, 0, 0, 1'b0, 2'd1, 2'd2);  status("dr_ign0_s", 1'b0, 1'b0, 3'd3, 1'b0);
    step("dr_last", 1, 1, 0, 1'b0, 2'd1, 2'd2);  status("dr_last_s", 1'b0, 1'b0, 3'd3, 1'b0);
    step("dr_new", 1, 1, 0, 1'b1, 2'd1, 2'd2);   status("dr_new_s", 1'b0, 1'b1, 3'd4, 1'b0);

    check("sb_drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
